// File: rtl/io_out_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : io_out_fifo_if
// Description : Valid/ready stream carrying tagged words out of io_out_fifo.
// Revision    : 1.0
// ============================================================================
interface io_out_fifo_if #(
  parameter int NUBITS = 32,
  parameter int AW     = 3
);
  logic              m_valid;
  logic              m_ready;
  logic [AW-1:0]     m_addr;
  logic [NUBITS-1:0] m_data;

  modport master (output m_valid, output m_addr, output m_data, input m_ready);
  modport slave  (input m_valid, input m_addr, input m_data, output m_ready);
endinterface
`default_nettype wire

// File: rtl/io_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_out_fifo
// Description : Tagged first-word-fall-through FIFO between the core's OUT
//               strobe and a back-pressuring stream; drops and flags on full.
// Revision    : 1.0
// ============================================================================
module io_out_fifo #(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 8,
  localparam int AW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int PW = $clog2(FDEPTH),
  localparam int CW = PW + 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              out_en,
  input  wire logic [AW-1:0]     addr_out,
  input  wire logic [NUBITS-1:0] data_out,
  io_out_fifo_if.master          m_if,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   ovf,
  input  wire logic              ovf_clr
);

  logic [AW+NUBITS-1:0] r_mem [FDEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_ovf;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [AW-1:0]        w_tag;
  logic [CW-1:0]        w_count_nxt;

  // A single-address core has no meaningful tag; store a constant zero.
  assign w_tag  = (NUIOOU > 1) ? addr_out : '0;
  assign w_pop  = (r_count != '0) && m_if.m_ready;
  assign w_push = out_en && (!r_full || w_pop);
  assign w_drop = out_en && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < FDEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_tag, data_out};
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FDEPTH));
      // Set has priority so a clear never hides a fresh overflow.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign m_if.m_valid               = (r_count != '0);
  assign {m_if.m_addr, m_if.m_data} = r_mem[r_rptr];
  assign count                      = r_count;
  assign full                       = r_full;
  assign ovf                        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_io_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_out_fifo
// Description : Scoreboard bench for io_out_fifo.
// Revision    : 1.0
// ============================================================================
module tb_io_out_fifo;
  localparam int NUBITS = 32;
  localparam int AW     = 3;
  localparam int FDEPTH = 8;
  localparam int CW     = 4;
  localparam int WW     = AW + NUBITS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              out_en = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [AW-1:0]     addr_out = '0;
  logic [NUBITS-1:0] data_out = '0;
  logic [CW-1:0]     count;
  logic              full;
  logic              ovf;

  io_out_fifo_if #(.NUBITS(NUBITS), .AW(AW)) mif ();

  io_out_fifo #(.NUBITS(NUBITS), .NUIOOU(8), .FDEPTH(FDEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .out_en   (out_en),
    .addr_out (addr_out),
    .data_out (data_out),
    .m_if     (mif),
    .count    (count),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          obs_valid;
  logic [WW-1:0] obs_word;
  logic          exp_valid;
  logic [WW-1:0] exp_word;
  int            n_checks = 0;
  int            n_fail = 0;

  // One clock of stimulus; head is sampled at the falling edge and the
  // scoreboard advances with the same push/pop rules the hardware must obey.
  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                       input logic rdy, input logic clr);
    logic pop, drop;
    out_en = en; addr_out = a; data_out = d; mif.m_ready = rdy; ovf_clr = clr;
    @(negedge clk);
    obs_valid = mif.m_valid;
    obs_word  = {mif.m_addr, mif.m_data};
    exp_valid = (q.size() != 0);
    exp_word  = exp_valid ? q[0] : '0;
    pop  = exp_valid && rdy;
    drop = en && (q.size() == FDEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (en && !drop) q.push_back({a, d});
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    out_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    mif.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (mif.m_valid !== 1'b0 || count !== '0 || full !== 1'b0 || ovf !== 1'b0 ||
          mif.m_data !== '0 || mif.m_addr !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d valid=%b count=%0d full=%b ovf=%b data=%h required 0", i,
                 mif.m_valid, count, full, ovf, mif.m_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    n_checks++;
    if (mif.m_valid !== 1'b1 || mif.m_addr !== 3'd3 || mif.m_data !== 32'hDEADBEEF || count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_push valid=%b addr=%0d data=%h count=%0d required 1 3 deadbeef 1",
               mif.m_valid, mif.m_addr, mif.m_data, count);
    end
    drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (mif.m_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pop valid=%b count=%0d required 0 0", mif.m_valid, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 17; i++) begin
      // 9 pushes with the consumer stalled, then 8 pops
      if (i <= 9) drive(1'b1, AW'(i), NUBITS'(i), 1'b0, 1'b0);
      else        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (obs_valid !== exp_valid || (exp_valid && obs_word !== exp_word)) begin
        n_fail++;
        $display("FAIL ovf_head step=%0d valid=%b word=%h required %b %h", i, obs_valid, obs_word, exp_valid, exp_word);
      end
      n_checks++;
      if (count !== CW'(q.size()) || full !== (q.size() == FDEPTH) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL ovf_status step=%0d count=%0d full=%b ovf=%b required %0d %b %b", i, count, full, ovf,
                 q.size(), (q.size() == FDEPTH), m_ovf);
      end
    end
    n_checks++;
    if (mif.m_valid !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained valid=%b ovf=%b required 0 1", mif.m_valid, ovf);
    end
  endtask

  task automatic test_ovf_clr();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear ovf=%b required 0", ovf);
    end
    for (int i = 0; i < FDEPTH; i++) drive(1'b1, AW'(i), 32'hA000 + i, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 32'hBAD, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b1 || ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL ovf_set_wins ovf=%b required 1", ovf);
    end
    for (int i = 0; i < FDEPTH; i++) drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL ovf_reclear ovf=%b count=%0d required 0 0", ovf, count);
    end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < 21; i++) begin
      // fill 8, 5 cycles of simultaneous push/pop at full, drain 8
      if (i < 8)       drive(1'b1, AW'(i), 32'hB000 + i, 1'b0, 1'b0);
      else if (i < 13) drive(1'b1, AW'(i), 32'hB000 + i, 1'b1, 1'b0);
      else             drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (obs_valid !== exp_valid || (exp_valid && obs_word !== exp_word)) begin
        n_fail++;
        $display("FAIL full_head step=%0d valid=%b word=%h required %b %h", i, obs_valid, obs_word, exp_valid, exp_word);
      end
      n_checks++;
      if (count !== CW'(q.size()) || full !== (q.size() == FDEPTH) || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL full_status step=%0d count=%0d full=%b ovf=%b required %0d %b 0", i, count, full, ovf,
                 q.size(), (q.size() == FDEPTH));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   cyc;
    logic en;
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || q.size() != 0) && cyc < 500) begin
      en = (sent < 20) && (q.size() < FDEPTH);
      drive(en, AW'(sent), 32'hC000 + sent, 1'($urandom_range(0, 1)), 1'b0);
      if (en) sent++;
      cyc++;
      n_checks++;
      if (obs_valid !== exp_valid || (exp_valid && obs_word !== exp_word)) begin
        n_fail++;
        $display("FAIL b2b_head cyc=%0d valid=%b word=%h required %b %h", cyc, obs_valid, obs_word, exp_valid, exp_word);
      end
      n_checks++;
      if (count !== CW'(q.size()) || full !== (q.size() == FDEPTH)) begin
        n_fail++;
        $display("FAIL b2b_status cyc=%0d count=%0d full=%b required %0d", cyc, count, full, q.size());
      end
    end
    n_checks++;
    if (sent != 20 || q.size() != 0 || mif.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done sent=%0d left=%0d valid=%b required 20 0 0", sent, q.size(), mif.m_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, AW'(i), 32'hD000 + i, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL areset_pre count=%0d required 5", count);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (mif.m_valid !== 1'b0 || count !== '0 || full !== 1'b0 || mif.m_data !== '0) begin
      n_fail++;
      $display("FAIL areset_now valid=%b count=%0d full=%b data=%h required 0 0 0 0", mif.m_valid, count, full, mif.m_data);
    end
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 3'd5, 32'hCAFEF00D, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (obs_valid !== exp_valid || (exp_valid && obs_word !== exp_word) || count !== CW'(q.size())) begin
        n_fail++;
        $display("FAIL areset_after i=%0d valid=%b word=%h count=%0d required %b %h %0d", i, obs_valid, obs_word,
                 count, exp_valid, exp_word, q.size());
      end
    end
  endtask

  initial begin
    mif.m_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_ovf_clr();
    test_full_passthrough();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
